// File: rtl/elevator_pkg.sv
// Floor types and constants shared by the elevator call path and the FSM.
package elevator_pkg;

  localparam int NUM_FLOORS = 4;

  typedef logic [1:0] floor_t;
  typedef logic [NUM_FLOORS-1:0] floor_mask_t;

  localparam floor_t FLOOR_GROUND = 2'd0;
  localparam floor_t FLOOR_L1     = 2'd1;
  localparam floor_t FLOOR_L2     = 2'd2;
  localparam floor_t FLOOR_L3     = 2'd3;

  function automatic floor_t floor_dist(
    input floor_t a,
    input floor_t b
  );
    return (a > b) ? floor_t'(a - b)
                   : floor_t'(b - a);
  endfunction

endpackage

// File: rtl/call_request_conditioner_if.sv
// Target-floor handshake and cabin status between the call
// conditioner (master) and the elevator FSM (slave).
interface call_request_conditioner_if;
  import elevator_pkg::*;

  logic        req_valid;
  logic        req_ready;
  floor_t      req_floor;
  floor_t      cur_floor;
  logic        arrived;
  floor_mask_t call_pending;

  modport master (
    output req_valid,
    output req_floor,
    output call_pending,
    input  req_ready,
    input  cur_floor,
    input  arrived
  );

  modport slave (
    input  req_valid,
    input  req_floor,
    input  call_pending,
    output req_ready,
    output cur_floor,
    output arrived
  );

endinterface

// File: rtl/call_request_conditioner_debouncer.sv
// Per-button synchroniser, optional debouncer (CALL_DEBOUNCE_EN)
// and one-cycle press pulse on the accepted rising level.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);

  logic sync1_q;
  logic sync2_q;
  logic press_q;
  logic press_d;

`ifdef CALL_DEBOUNCE_EN
  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          level_q;
  logic          level_d;

  // Counter tracks consecutive samples disagreeing with level_q.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
      cnt_d   = '0;
      level_d = sync2_q;
      press_d = sync2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end
`else
  localparam bit unused_cfg = (DEBOUNCE_CYCLES >= 1);

  always_comb begin
    press_d = sync1_q & ~sync2_q;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/call_request_conditioner.sv
// Latches call buttons as pending calls and offers the nearest one
// to the FSM. Debounce is enabled by defining CALL_DEBOUNCE_EN.
module call_request_conditioner
  import elevator_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_FLOORS-1:0]  btn_in,
  call_request_conditioner_if.master req
);

  floor_mask_t press;
  floor_mask_t pending_q;
  floor_mask_t pending_d;
  floor_mask_t disp_q;
  floor_mask_t disp_d;
  floor_mask_t clr;
  floor_mask_t cand;
  floor_mask_t xfer;
  logic        valid_q;
  logic        valid_d;
  floor_t      floor_q;
  floor_t      floor_d;
  floor_t      pick;
  logic [2:0]  best_d;
  logic        drop;
  logic        take;

  for (genvar f = 0; f < NUM_FLOORS; f++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_i   (btn_in[f]),
      .press_o (press[f])
    );
  end

  always_comb begin
    clr = '0;
    if (req.arrived) clr[req.cur_floor] = 1'b1;
    drop = valid_q & clr[floor_q];
    take = valid_q & req.req_ready & ~drop;
    xfer = '0;
    if (take) xfer[floor_q] = 1'b1;
    pending_d = (pending_q | press) & ~clr;
    disp_d    = (disp_q | xfer) & ~clr;
    // Floors being cleared this cycle are not worth offering.
    cand = pending_q & ~disp_q & ~clr;
  end

  always_comb begin
    pick   = FLOOR_GROUND;
    best_d = 3'd4;
    for (int f = 0; f < NUM_FLOORS; f++) begin
      if (cand[f] &&
          {1'b0, floor_dist(floor_t'(f), req.cur_floor)}
            < best_d) begin
        best_d = {1'b0, floor_dist(floor_t'(f), req.cur_floor)};
        pick   = floor_t'(f);
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    floor_d = floor_q;
    if (valid_q) begin
      if (drop || take) valid_d = 1'b0;
    end else if (|cand) begin
      valid_d = 1'b1;
      floor_d = pick;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      disp_q    <= '0;
      valid_q   <= 1'b0;
      floor_q   <= FLOOR_GROUND;
    end else begin
      pending_q <= pending_d;
      disp_q    <= disp_d;
      valid_q   <= valid_d;
      floor_q   <= floor_d;
    end
  end

  assign req.req_valid    = valid_q;
  assign req.req_floor    = floor_q;
  assign req.call_pending = pending_q;

endmodule

// File: tb/tb_call_request_conditioner.sv
// Directed bench for call_request_conditioner; latencies follow
// whether CALL_DEBOUNCE_EN is defined.
module tb_call_request_conditioner;
  import elevator_pkg::*;

  localparam int N = 4;
`ifdef CALL_DEBOUNCE_EN
  localparam int LAT = N;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn_in = 4'b0;
  int         n_run = 0;
  int         n_fail = 0;

  call_request_conditioner_if bus ();

  call_request_conditioner #(
    .DEBOUNCE_CYCLES (N)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_in (btn_in),
    .req    (bus.master)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string      tag,
    input logic [7:0] got,
    input logic [7:0] exp
  );
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] m);
    btn_in = m;
    repeat (8) tick();
    btn_in = 4'b0;
    repeat (8) tick();
  endtask

  task automatic arrive(input floor_t f);
    bus.cur_floor = f;
    bus.arrived   = 1'b1;
    tick();
    bus.arrived   = 1'b0;
  endtask

  task automatic accept();
    bus.req_ready = 1'b1;
    tick();
    bus.req_ready = 1'b0;
  endtask

  initial begin
    bus.req_ready = 1'b0;
    bus.cur_floor = 2'd0;
    bus.arrived   = 1'b0;
    repeat (3) tick();
    check("rst_valid", {7'b0, bus.req_valid}, 8'h0);
    check("rst_pend", {4'b0, bus.call_pending}, 8'h0);
    #2 rst_n = 1'b1;
    tick();

    // L2 press: latency to pending and to offer, offer held.
    btn_in = 4'b0100;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 10) btn_in = 4'b0;
      if (k == 2 + LAT)
        check("l2_pend_early", {4'b0, bus.call_pending}, 8'h0);
      if (k == 3 + LAT) begin
        check("l2_pend", {4'b0, bus.call_pending}, 8'h04);
        check("l2_valid_early", {7'b0, bus.req_valid}, 8'h0);
      end
      if (k == 4 + LAT) begin
        check("l2_valid", {7'b0, bus.req_valid}, 8'h1);
        check("l2_floor", {6'b0, bus.req_floor}, 8'h2);
      end
    end
    check("l2_hold_valid", {7'b0, bus.req_valid}, 8'h1);
    check("l2_hold_floor", {6'b0, bus.req_floor}, 8'h2);
    accept();
    check("l2_xfer_drop", {7'b0, bus.req_valid}, 8'h0);
    tick();
    check("l2_no_reoffer", {7'b0, bus.req_valid}, 8'h0);
    arrive(2'd2);
    check("l2_arrive_clr", {4'b0, bus.call_pending}, 8'h0);
    bus.cur_floor = 2'd0;

    // Short pulse on L1.
    btn_in = 4'b0010;
    repeat (3) tick();
    btn_in = 4'b0;
    repeat (12) tick();
`ifdef CALL_DEBOUNCE_EN
    check("glitch_pend", {4'b0, bus.call_pending}, 8'h0);
    check("glitch_valid", {7'b0, bus.req_valid}, 8'h0);
`else
    check("pulse_pend", {4'b0, bus.call_pending}, 8'h02);
    check("pulse_floor", {6'b0, bus.req_floor}, 8'h1);
    accept();
    arrive(2'd1);
    check("pulse_clr", {4'b0, bus.call_pending}, 8'h0);
`endif

    // L1 and L3 from floor 2: tie goes to the lower floor.
    bus.cur_floor = 2'd2;
    press(4'b1010);
    check("tie_pend", {4'b0, bus.call_pending}, 8'h0a);
    check("tie_valid", {7'b0, bus.req_valid}, 8'h1);
    check("tie_floor", {6'b0, bus.req_floor}, 8'h1);
    accept();
    check("tie_gap", {7'b0, bus.req_valid}, 8'h0);
    tick();
    check("next_valid", {7'b0, bus.req_valid}, 8'h1);
    check("next_floor", {6'b0, bus.req_floor}, 8'h3);
    accept();

    // Arrival at 3 clears it; re-press re-offers it.
    arrive(2'd3);
    check("l3_clr", {4'b0, bus.call_pending}, 8'h02);
    tick();
    check("l3_idle", {7'b0, bus.req_valid}, 8'h0);
    press(4'b1000);
    check("l3_relatch", {4'b0, bus.call_pending}, 8'h0a);
    check("l3_reoffer", {6'b0, bus.req_floor}, 8'h3);
    check("l3_revalid", {7'b0, bus.req_valid}, 8'h1);
    accept();
    arrive(2'd1);
    arrive(2'd3);
    check("all_clr", {4'b0, bus.call_pending}, 8'h0);

    // Press on L1 in the same cycle as arrival at L1.
    btn_in = 4'b0010;
    repeat (2 + LAT) tick();
    arrive(2'd1);
    check("same_cyc_pend", {4'b0, bus.call_pending}, 8'h0);
    repeat (6) tick();
    btn_in = 4'b0;
    repeat (8) tick();
    check("same_cyc_later", {4'b0, bus.call_pending}, 8'h0);
    check("same_cyc_valid", {7'b0, bus.req_valid}, 8'h0);

    // Offered floor cleared by arrival before acceptance.
    bus.cur_floor = 2'd0;
    press(4'b0100);
    check("drop_offer", {6'b0, bus.req_floor}, 8'h2);
    arrive(2'd2);
    check("drop_valid", {7'b0, bus.req_valid}, 8'h0);
    check("drop_pend", {4'b0, bus.call_pending}, 8'h0);
    bus.cur_floor = 2'd0;
    tick();
    check("drop_stay", {7'b0, bus.req_valid}, 8'h0);

    // Asynchronous reset mid-handshake.
    press(4'b0111);
    check("pre_rst_pend", {4'b0, bus.call_pending}, 8'h07);
    check("pre_rst_floor", {6'b0, bus.req_floor}, 8'h0);
    check("pre_rst_valid", {7'b0, bus.req_valid}, 8'h1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", {7'b0, bus.req_valid}, 8'h0);
    check("arst_pend", {4'b0, bus.call_pending}, 8'h0);
    check("arst_floor", {6'b0, bus.req_floor}, 8'h0);
    repeat (2) tick();
    #2 rst_n = 1'b1;
    repeat (6) tick();
    check("post_rst_valid", {7'b0, bus.req_valid}, 8'h0);
    check("post_rst_pend", {4'b0, bus.call_pending}, 8'h0);
    press(4'b0001);
    check("post_rst_offer", {7'b0, bus.req_valid}, 8'h1);
    check("post_rst_flr", {6'b0, bus.req_floor}, 8'h0);
    check("post_rst_p", {4'b0, bus.call_pending}, 8'h01);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/call_request_conditioner.md
# call_request_conditioner

Input stage in front of the elevator FSM: takes the four raw call buttons (ground, L1, L2, L3) from the top-level pins, then synchronises and debounces them. It latches each press as a pending call and offers the FSM one target floor at a time over a valid/ready handshake. A call stays pending until the FSM reports arrival at that floor.

## Interface
- DEBOUNCE_CYCLES, 4: consecutive stable samples required before a button level change is accepted (≥1).
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- btn_in  input  4  raw buttons, bit0 ground, bit1 L1, bit2 L2, bit3 L3; active high; asynchronous to clk.
- cur_floor  input  2  current cabin floor from FSM (0..3).
- arrived  input  1  one-cycle strobe: cabin stopped at cur_floor, doors opening.
- req_ready  input  1  FSM accepts a target floor.
- req_valid  output  1  target floor offered.
- req_floor  output  2  offered target floor.
- call_pending  output  4  latched calls, same bit order as btn_in; drives call indicators.

## Operation
- Per button: 2-flop synchroniser, then debouncer. The debouncer state flips only after DEBOUNCE_CYCLES consecutive synchronised samples differ from it. Its counter resets whenever a sample equals the state.
- Press event: rising edge of the debounced level. It is a one-cycle pulse. Release and held buttons generate nothing further.
- pending[f] set on press[f]. dispatched[f] set when floor f is handed off (req_valid & req_ready).
- arrived: clears pending[cur_floor] and dispatched[cur_floor].
- Same-cycle press[f] and arrived with cur_floor==f: clear wins, so no call is latched.
- Press on an already pending floor: no effect.
- Candidate set = pending & ~dispatched.
- Selection happens when req_valid is low and the candidate set is non-empty. The chosen floor is the one with minimum |f − cur_floor|, with ties going to the lower floor. A candidate equal to cur_floor (distance 0) is legal.
- Handshake: once req_valid rises, req_floor is frozen until req_valid & req_ready. req_valid then drops for at least one cycle before the next offer.
- Offered floor cleared by arrival before acceptance: req_valid drops on the next edge and no transfer occurs.
- Reset (any time, including mid-debounce or mid-handshake):
  - synchronisers, debounce counters and states, pending, dispatched all cleared;
  - req_valid=0, req_floor=0, call_pending=0.

## Timing
- N = DEBOUNCE_CYCLES. Raw edge sampled at clock edge 0.
- Synchroniser output changes at edge 2, and the debounced state flips at edge 2+N.
- pending and call_pending set at edge 3+N.
- req_valid rises at edge 4+N if idle and the floor is selected.
- Glitch shorter than N synchronised cycles: filtered, no pending.
- call_pending clears on the edge where arrived is sampled. req_valid can re-assert no earlier than 2 edges after a transfer.
- All outputs registered; no combinational path from any input to any output.

## Configuration
- CALL_DEBOUNCE_EN defined:
  - debouncer present as above.
- Not defined:
  - debounced state = synchroniser output; DEBOUNCE_CYCLES is ignored;
  - pending at edge 3, req_valid at edge 4;
  - every synchronised edge counts as a press.

## Structure
- Shared package elevator_pkg:
  - floor_t (2-bit) and NUM_FLOORS=4;
  - constants FLOOR_GROUND, FLOOR_L1, FLOOR_L2, FLOOR_L3;
  - to be reused by the FSM.
- Sub-module button_debouncer (synchroniser + debouncer + edge pulse, parameter DEBOUNCE_CYCLES), instantiated 4 times. Selection, pending/dispatched registers and handshake stay in the top of this block.

## Test plan
- CALL_DEBOUNCE_EN, N=4, cur_floor=0: btn_in[2] high 10 cycles → call_pending=4'b0100 at edge 7; req_valid=1, req_floor=2 at edge 8; held until req_ready.
- btn_in[1] pulse of 3 cycles, N=4 → call_pending stays 0, req_valid stays 0.
- Pending L1 and L3, cur_floor=2, idle → req_floor=1 (tie to lower). After acceptance, next offer is req_floor=3.
- Accepted floor 3, then arrived with cur_floor=3 → call_pending[3] clears that edge. Pressing L3 again re-latches it and re-offers it.
- Press on floor 1 in the same cycle as arrived with cur_floor=1 → call_pending[1] stays 0.
- rst_n low while req_valid=1 with three pending calls → all outputs 0 immediately (async). No offer until new presses after release.
